// File: rtl/param_serializer.sv
// Parameterised parallel-to-serial converter for the UART TX datapath.
// A one-word holding buffer (valid/ready) feeds a shift register so that
// consecutive words can be sent back-to-back with no idle bit between them.
// Every output is registered; no input reaches an output combinationally.
module param_serializer #(
  parameter int DATA_WIDTH = 8,
  parameter bit MSB_FIRST  = 1'b0,
  parameter bit IDLE_LEVEL = 1'b1
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [DATA_WIDTH-1:0]         P_DATA,
  input  logic                          Data_Valid,
  output logic                          Data_Ready,
  input  logic                          ser_en,
  output logic                          ser_data,
  output logic                          ser_done,
  output logic                          ser_busy,
  output logic [$clog2(DATA_WIDTH)-1:0] bit_idx
);

  localparam int IW = $clog2(DATA_WIDTH);
  localparam logic [IW-1:0] LAST   = IW'(DATA_WIDTH - 1);
  localparam logic [IW-1:0] PENULT = IW'(DATA_WIDTH - 2);
  localparam logic [IW-1:0] ONE    = IW'(1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                state_q;
  logic [DATA_WIDTH-1:0] hold_q, shreg_q;
  logic                  hold_full_q, hold_full_d, rdy_q;
  logic                  sdata_q, done_q, busy_q;
  logic [IW-1:0]         idx_q;

  logic                  accept, last, load;
  logic                  first_bit, next_bit;
  logic [DATA_WIDTH-1:0] hold_rest, shreg_shift;

  // Rdy_q always mirrors !hold_full_q, so accept and load can never coincide:
  // a word must sit in the buffer for at least one cycle before it is sent.
  assign accept = Data_Valid && rdy_q;
  assign last   = (state_q == SHIFT) && (idx_q == LAST);
  assign load   = ser_en && hold_full_q && ((state_q == IDLE) || last);

  // Fixed-position bit pick and shift toward the output end, refilled with
  // the idle level so the register never holds stale data bits.
  assign first_bit   = MSB_FIRST ? hold_q[DATA_WIDTH-1] : hold_q[0];
  assign next_bit    = MSB_FIRST ? shreg_q[DATA_WIDTH-1] : shreg_q[0];
  assign hold_rest   = MSB_FIRST ? {hold_q[DATA_WIDTH-2:0], IDLE_LEVEL}
                                 : {IDLE_LEVEL, hold_q[DATA_WIDTH-1:1]};
  assign shreg_shift = MSB_FIRST ? {shreg_q[DATA_WIDTH-2:0], IDLE_LEVEL}
                                 : {IDLE_LEVEL, shreg_q[DATA_WIDTH-1:1]};

  // Next occupancy of the holding buffer.
  always_comb begin
    hold_full_d = hold_full_q;
    if (accept)    hold_full_d = 1'b1;
    else if (load) hold_full_d = 1'b0;
  end

  // Holding buffer: capture on handshake; held word is never overwritten.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hold_q      <= '1;
      hold_full_q <= 1'b0;
      rdy_q       <= 1'b1;
    end else begin
      if (accept) hold_q <= P_DATA;
      hold_full_q <= hold_full_d;
      rdy_q       <= !hold_full_d;
    end
  end

  // Shift FSM with registered line outputs; dropping ser_en aborts the word.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      shreg_q <= '1;
      sdata_q <= IDLE_LEVEL;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      if (load) begin
        // Start of a word, either from idle or chained after the last bit.
        state_q <= SHIFT;
        shreg_q <= hold_rest;
        sdata_q <= first_bit;
        done_q  <= 1'b0;
        busy_q  <= 1'b1;
        idx_q   <= '0;
      end else if (state_q == SHIFT && ser_en && !last) begin
        shreg_q <= shreg_shift;
        sdata_q <= next_bit;
        done_q  <= (idx_q == PENULT);
        idx_q   <= idx_q + ONE;
      end else begin
        // Idle, end of word with nothing queued, or abort.
        state_q <= IDLE;
        sdata_q <= IDLE_LEVEL;
        done_q  <= 1'b0;
        busy_q  <= 1'b0;
        idx_q   <= '0;
      end
    end
  end

  assign Data_Ready = rdy_q;
  assign ser_data   = sdata_q;
  assign ser_done   = done_q;
  assign ser_busy   = busy_q;
  assign bit_idx    = idx_q;

endmodule

// File: tb/tb_param_serializer.sv
// Bench for param_serializer: three configurations (8-bit LSB-first,
// 8-bit MSB-first, 5-bit LSB-first idle-low) share one stimulus stream and
// are compared each cycle against a word/position reference model.
module tb_param_serializer;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] d;
  logic       v, e;
  logic [2:0] rdy, sd, dn, by;
  logic [2:0] bi0, bi1, bi2;

  int total = 0;
  int bad   = 0;

  // Reference model state per instance: pos = -1 means idle line.
  int         DW  [3] = '{8, 8, 5};
  bit         MSB [3] = '{1'b0, 1'b1, 1'b0};
  bit         IDL [3] = '{1'b1, 1'b1, 1'b0};
  int         pos [3];
  bit         hv  [3];
  logic [7:0] hw  [3];
  logic [7:0] cw  [3];

  always #5 CLK = ~CLK;

  param_serializer #(.DATA_WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) u0 (
    .CLK(CLK), .RST(RST), .P_DATA(d), .Data_Valid(v), .Data_Ready(rdy[0]),
    .ser_en(e), .ser_data(sd[0]), .ser_done(dn[0]), .ser_busy(by[0]), .bit_idx(bi0));
  param_serializer #(.DATA_WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) u1 (
    .CLK(CLK), .RST(RST), .P_DATA(d), .Data_Valid(v), .Data_Ready(rdy[1]),
    .ser_en(e), .ser_data(sd[1]), .ser_done(dn[1]), .ser_busy(by[1]), .bit_idx(bi1));
  param_serializer #(.DATA_WIDTH(5), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u2 (
    .CLK(CLK), .RST(RST), .P_DATA(d[4:0]), .Data_Valid(v), .Data_Ready(rdy[2]),
    .ser_en(e), .ser_data(sd[2]), .ser_done(dn[2]), .ser_busy(by[2]), .bit_idx(bi2));

  task automatic chk(input string tag, input int k, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s inst=%0d t=%0t got=%0h exp=%0h", tag, k, $time, got, exp);
    end
  endtask

  task automatic check_all();
    logic [2:0] idx_obs;
    logic       bit_exp;
    int         sel;
    for (int k = 0; k < 3; k++) begin
      idx_obs = (k == 0) ? bi0 : (k == 1) ? bi1 : bi2;
      if (pos[k] < 0) bit_exp = IDL[k];
      else begin
        sel = MSB[k] ? (DW[k] - 1 - pos[k]) : pos[k];
        bit_exp = cw[k][sel];
      end
      chk("ser_data",   k, 32'(sd[k]),  32'(bit_exp));
      chk("ser_done",   k, 32'(dn[k]),  32'(pos[k] == DW[k] - 1));
      chk("ser_busy",   k, 32'(by[k]),  32'(pos[k] >= 0));
      chk("bit_idx",    k, 32'(idx_obs), (pos[k] < 0) ? 32'd0 : 32'(pos[k]));
      chk("Data_Ready", k, 32'(rdy[k]), 32'(!hv[k]));
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      pos[k] = -1;
      hv[k]  = 1'b0;
      hw[k]  = '1;
      cw[k]  = '1;
    end
  endtask

  // Advance the model by one edge using the inputs currently applied,
  // clock the DUTs, then compare everything just after the edge.
  task automatic tick();
    bit acc;
    for (int k = 0; k < 3; k++) begin
      acc = v && !hv[k];
      if (pos[k] >= 0) begin
        if (!e) pos[k] = -1;
        else if (pos[k] == DW[k] - 1) begin
          if (hv[k]) begin cw[k] = hw[k]; hv[k] = 1'b0; pos[k] = 0; end
          else pos[k] = -1;
        end else pos[k] = pos[k] + 1;
      end else if (e && hv[k]) begin
        cw[k] = hw[k]; hv[k] = 1'b0; pos[k] = 0;
      end
      if (acc) begin hv[k] = 1'b1; hw[k] = d; end
    end
    @(posedge CLK);
    #1;
    check_all();
  endtask

  task automatic push(input logic [7:0] w);
    v = 1'b1; d = w;
    tick();
    v = 1'b0; d = 8'h00;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  initial begin
    RST = 1'b1; v = 1'b0; e = 1'b0; d = 8'h00;
    model_reset();
    #1 check_all();
    @(posedge CLK); #1 check_all();
    RST = 1'b0;

    // Single word 0xC1 on all configs, then line returns to idle.
    push(8'hC1); e = 1'b1; run(10); e = 1'b0; run(2);

    // Back-to-back 0xC1 then 0x0F pushed mid-word, enable held high.
    push(8'hC1); e = 1'b1; run(3); push(8'h0F); run(20); e = 1'b0; run(1);

    // Abort after 3 bits with 0x55 already held; 0x55 then starts fresh.
    push(8'hC1); e = 1'b1; run(2); push(8'h55); e = 1'b0; run(2);
    e = 1'b1; run(10); e = 1'b0; run(1);

    // Overflow: 0xAA offered while 0x55 is held must be dropped.
    push(8'h55); push(8'hAA); e = 1'b1; run(12); e = 1'b0; run(1);

    // Random traffic with mostly-high enable.
    repeat (400) begin
      v = 1'($urandom_range(0, 1));
      d = 8'($urandom);
      e = ($urandom_range(0, 7) != 0);
      tick();
    end
    v = 1'b0; e = 1'b0; run(2);

    // Asynchronous reset in the middle of a word, with a word also held.
    push(8'hC1); e = 1'b1; run(3); push(8'h3C); run(1);
    RST = 1'b1;
    model_reset();
    #1 check_all();
    #1 RST = 1'b0;
    run(3); e = 1'b0;
    push(8'h96); e = 1'b1; run(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/param_serializer.md
Name: param_serializer

Overview:
Parametrised parallel-to-serial converter for the UART TX datapath. It generalises the fixed 8-bit LSB-first serializer with configurable data width, bit order and idle line level. A one-word holding buffer with a valid/ready handshake allows back-to-back words with no idle gap. The FSM asserts ser_en to drive shifting, and the block reports per-word completion to the FSM.

Parameters:
DATA_WIDTH, 8, word width in bits; legal range is 2 to 32.
MSB_FIRST, 0, bit order: 0 sends bit 0 first, 1 sends bit DATA_WIDTH-1 first.
IDLE_LEVEL, 1, value driven on ser_data when not shifting.

Ports:
CLK  input  1  clock; all state changes on the rising edge.
RST  input  1  asynchronous, active-high reset.
P_DATA  input  DATA_WIDTH  parallel word to send.
Data_Valid  input  1  P_DATA is valid.
Data_Ready  output  1  holding buffer is empty; a word is accepted on an edge where Data_Valid and Data_Ready are both high.
ser_en  input  1  shift enable from the TX FSM.
ser_data  output  1  serial bit (registered).
ser_done  output  1  high while the last bit of a word is on ser_data.
ser_busy  output  1  high while a word is being shifted.
bit_idx  output  $clog2(DATA_WIDTH)  index within the word of the bit currently on ser_data; 0 when idle.

Behaviour:
- Reset (asynchronous, RST=1), all outputs and state:
  - ser_data = IDLE_LEVEL; ser_done = 0; ser_busy = 0; bit_idx = 0; Data_Ready = 1.
  - Holding register = all ones; shift register = all ones; FSM in IDLE.
- Holding buffer:
  - Data_Ready is registered and equals !hold_full.
  - Accept on an edge with Data_Valid && Data_Ready: hold_full is set and the word is captured.
  - A transfer to the shift register clears hold_full, so Data_Ready = 1 from the next cycle.
  - Data_Valid while Data_Ready = 0 is ignored; the held word is never overwritten.
- FSM states: IDLE, SHIFT.
- IDLE:
  - Drives ser_data = IDLE_LEVEL, ser_busy = 0, ser_done = 0.
  - On an edge with ser_en && hold_full: load the shift register from the holding register and clear hold_full.
  - On that same edge: ser_data takes the first bit (bit 0, or bit DATA_WIDTH-1 if MSB_FIRST), bit_idx = 0, ser_busy = 1, and the FSM moves to SHIFT.
  - Latency: the first bit is visible one cycle after the enabling edge.
  - ser_en high with hold_full = 0: stay in IDLE.
  - A word is not accepted and transferred on the same edge; it needs at least one cycle in the holding buffer first.
- SHIFT:
  - Each edge with ser_en = 1 outputs the next bit and increments bit_idx.
  - ser_done = 1 exactly in the cycle bit_idx = DATA_WIDTH-1; otherwise ser_done = 0.
  - The word occupies DATA_WIDTH cycles.
- End of word (edge after the last bit):
  - If ser_en && hold_full: chain directly. Load the next word, output its first bit, bit_idx = 0, ser_busy stays 1, no idle cycle.
  - Otherwise: return to IDLE with ser_data = IDLE_LEVEL and bit_idx = 0.
- Abort:
  - ser_en = 0 on any edge in SHIFT: immediately go to IDLE with ser_data = IDLE_LEVEL, ser_done = 0, bit_idx = 0, ser_busy = 0.
  - The partially sent word is discarded and is not retransmitted.
  - The holding buffer is unaffected.
- Reset mid-word: all state returns to reset values immediately; both the buffered and the shifting words are lost.
- Bit selection: shift toward the output end, right for LSB-first and left for MSB-first, filling with IDLE_LEVEL. Do not use a variable index.
- No combinational path from any input to any output.

Test Plan:
1. Reset with RST = 1 mid-operation -> same cycle: ser_data = 1, ser_done = 0, ser_busy = 0, Data_Ready = 1, bit_idx = 0.
2. DATA_WIDTH = 8, MSB_FIRST = 0, load 0xC1, ser_en = 1:
   - ser_data = 1,0,0,0,0,0,1,1 on the 8 cycles after the enabling edge.
   - ser_done high only on the 8th bit; then ser_data = 1.
3. Same stimulus with MSB_FIRST = 1 -> ser_data = 1,1,0,0,0,0,0,1; bit_idx steps 0 to 7.
4. Back-to-back: 0xC1, then 0x0F pushed during the first word, ser_en held high:
   - 16 consecutive bits: 1,0,0,0,0,0,1,1,1,1,1,1,0,0,0,0.
   - ser_done pulses at bits 8 and 16; ser_busy never drops.
   - Data_Ready is 0 while 0x0F is held.
5. Abort: drop ser_en after 3 bits of 0xC1:
   - Next cycle ser_data = 1, ser_busy = 0, no ser_done.
   - A word already held (0x55) starts fresh from bit 0 when ser_en returns.
6. Overflow: Data_Valid with 0xAA while 0x55 is held and Data_Ready = 0 -> 0x55 is transmitted and 0xAA is dropped. DATA_WIDTH = 5, IDLE_LEVEL = 0: idle line is 0 and ser_done falls on the 5th bit.
